// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and helpers for the pipeline hazard/stall sequencer.
//   hz_state_e : sequencer state encoding
//   sat_inc    : saturating increment, saturates at i_max (operands up to 64 bits)
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EX_WAIT  = 2'd2,
        HALT     = 2'd3
    } hz_state_e;

    function automatic logic [63:0] sat_inc(input logic [63:0] i_val,
                                            input logic [63:0] i_max);
        return (i_val >= i_max) ? i_val : i_val + 64'd1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// comparator_5bit
//   Equality compare of two register indices.
//   i_a, i_b : 5-bit register indices
//   o_eq     : 1 when equal
module comparator_5bit (
    input  logic [4:0] i_a,
    input  logic [4:0] i_b,
    output logic       o_eq
);
    assign o_eq = (i_a == i_b);
endmodule

// load_use_detect
//   Flags a load in EX whose result is needed by the instruction in ID; this
//   cannot be forwarded in time and needs a one-cycle bubble.
//   i_rs1, i_rs2            : ID source register indices
//   i_none_rs1, i_none_rs2  : corresponding field is not a register source
//   i_ex_rd, i_none_rd      : EX destination index / EX has no destination
//   i_wb, i_memread         : EX writes regfile / EX is a load
//   o_load_use              : hazard present
module load_use_detect (
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_none_rs1,
    input  logic       i_none_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_none_rd,
    input  logic       i_wb,
    input  logic       i_memread,
    output logic       o_load_use
);
    logic w_eq1;
    logic w_eq2;
    logic w_producer;

    comparator_5bit u_cmp_rs1 (.i_a(i_rs1), .i_b(i_ex_rd), .o_eq(w_eq1));
    comparator_5bit u_cmp_rs2 (.i_a(i_rs2), .i_b(i_ex_rd), .o_eq(w_eq2));

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_producer = i_memread & i_wb & ~i_none_rd & (i_ex_rd != 5'd0);
    assign o_load_use = w_producer & ((w_eq1 & ~i_none_rs1) | (w_eq2 & ~i_none_rs2));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Central pipeline sequencer for the 5-stage core. Each cycle picks one
//   action by fixed priority (halt, mem wait, EX busy, mispredict, load-use)
//   and drives the pipeline register enables/flushes combinationally.
//   A data-memory wait lasting MEM_TIMEOUT cycles halts the core with a
//   sticky error that only reset clears.
//   Inputs : clk_i, rst_i (async, active-high), ID sources and EX destination
//            info, mispredict_EX, ex_busy, mem_req_MEM, dmem_ack
//   Outputs: pc/IF_ID/ID_EX/EX_MEM/MEM_WB enables and flushes, halt_o,
//            mem_timeout_err, stall_cnt, flush_cnt (saturating)
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   RUN      | normal flow, no long-latency wait in progress
//   MEM_WAIT | data memory access outstanding, wait_cnt counting
//   EX_WAIT  | multicycle EX operation in progress
//   HALT     | mem wait timed out; pipeline frozen until reset
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             NONE_RS1_ID,
    input  logic             NONE_RS2_ID,
    input  logic [4:0]       EX_rd,
    input  logic             NONE_RD_EX,
    input  logic             WB_EX,
    input  logic             MEMREAD_EX,
    input  logic             mispredict_EX,
    input  logic             ex_busy,
    input  logic             mem_req_MEM,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             IF_ID_en,
    output logic             ID_EX_en,
    output logic             EX_MEM_en,
    output logic             MEM_WB_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_flush,
    output logic             halt_o,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONES   = '1;

    hz_state_e         r_state;
    hz_state_e         w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_halt;
    logic              r_err;

    logic              w_load_use;
    logic              w_mem_stall;
    logic              w_stall_evt;
    logic              w_flush_evt;
    logic [CNT_W-1:0]  w_stall_inc;
    logic [CNT_W-1:0]  w_flush_inc;

    load_use_detect u_lud (
        .i_rs1      (rs1_ID),
        .i_rs2      (rs2_ID),
        .i_none_rs1 (NONE_RS1_ID),
        .i_none_rs2 (NONE_RS2_ID),
        .i_ex_rd    (EX_rd),
        .i_none_rd  (NONE_RD_EX),
        .i_wb       (WB_EX),
        .i_memread  (MEMREAD_EX),
        .o_load_use (w_load_use)
    );

    assign w_mem_stall = mem_req_MEM & ~dmem_ack;

    assign w_stall_inc = CNT_W'(sat_inc(64'(r_stall_cnt), 64'(CNT_ONES)));
    assign w_flush_inc = CNT_W'(sat_inc(64'(r_flush_cnt), 64'(CNT_ONES)));

    // Priority encoder. Lower-priority events are not stored: the frozen
    // EX instruction keeps asserting them until they win a cycle.
    always_comb begin
        pc_en        = 1'b1;
        IF_ID_en     = 1'b1;
        ID_EX_en     = 1'b1;
        EX_MEM_en    = 1'b1;
        MEM_WB_en    = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        w_stall_evt  = 1'b0;
        w_flush_evt  = 1'b0;

        if (r_state == HALT) begin
            pc_en     = 1'b0;
            IF_ID_en  = 1'b0;
            ID_EX_en  = 1'b0;
            EX_MEM_en = 1'b0;
            MEM_WB_en = 1'b0;
        end else if (w_mem_stall) begin
            pc_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EX_en     = 1'b0;
            EX_MEM_en    = 1'b0;
            MEM_WB_flush = 1'b1;
            w_stall_evt  = 1'b1;
        end else if (ex_busy) begin
            pc_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EX_en     = 1'b0;
            EX_MEM_flush = 1'b1;
            w_stall_evt  = 1'b1;
        end else if (mispredict_EX) begin
            // The load-use consumer sits in ID and is squashed here anyway.
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            w_flush_evt = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
            w_stall_evt = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (w_mem_stall)  w_state_next = MEM_WAIT;
                else if (ex_busy) w_state_next = EX_WAIT;
            end
            MEM_WAIT: begin
                if (w_mem_stall) begin
                    if (r_wait_cnt == WAIT_LIMIT) w_state_next = HALT;
                end else if (ex_busy) begin
                    w_state_next = EX_WAIT;
                end else begin
                    w_state_next = RUN;
                end
            end
            EX_WAIT: begin
                if (w_mem_stall)   w_state_next = MEM_WAIT;
                else if (!ex_busy) w_state_next = RUN;
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_halt      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Holding at the limit is safe: that cycle either moves to HALT
            // or, on ack, clears the count.
            if (!w_mem_stall)
                r_wait_cnt <= '0;
            else if (r_state != HALT && r_wait_cnt != WAIT_LIMIT)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

            if (w_stall_evt) r_stall_cnt <= w_stall_inc;
            if (w_flush_evt) r_flush_cnt <= w_flush_inc;

            if (w_state_next == HALT) begin
                r_halt <= 1'b1;
                r_err  <= 1'b1;
            end
        end
    end

    assign halt_o          = r_halt;
    assign mem_timeout_err = r_err;
    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;

endmodule
